data_bus_bridge: RTL and testbench
==================================

# data_bus_bridge

Sequential bridge between the core's load/store unit and the external data bus. It accepts the word-aligned address, positioned write data and byte mask produced by `memory_controller`. It runs one handshaked bus transaction per access, stalling the core until the access completes. It returns the raw 32-bit load word to `memory_controller` for byte/half extraction and sign extension. It also flags bus errors and timeouts.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles allowed from entering REQ to completion before a fault; legal range 1..65535.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `core_ld`  in  1  load requested by the current instruction.
- `core_st`  in  1  store requested by the current instruction.
- `memory_addr`  in  32  word-aligned address from `memory_controller`; bits [1:0] are 0.
- `write_data`  in  32  lane-positioned store data.
- `write_mask`  in  4  byte enables; bit n enables byte lane n.
- `load_data`  out  32  registered load word; feeds `memory_controller`.
- `stall`  out  1  freeze the PC and pipeline while high.
- `mem_fault`  out  1  one-cycle pulse on bus error or timeout.
- `bus_req`  out  1  transaction request; held until granted.
- `bus_we`  out  1  1 = write, 0 = read.
- `bus_addr`  out  32  latched address.
- `bus_wdata`  out  32  latched write data.
- `bus_wmask`  out  4  latched mask; forced to 0 on reads.
- `bus_gnt`  in  1  request accepted this cycle.
- `bus_rvalid`  in  1  response valid (read data or write acknowledge).
- `bus_rdata`  in  32  read data; sampled only when `bus_rvalid`=1.
- `bus_err`  in  1  error qualifier; sampled only when `bus_rvalid`=1.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - On `core_ld|core_st`, latch address, data and mask into the bus registers.
  - Latch `bus_we`=`core_st`. Store wins if both are high.
  - Go to REQ.
  - Exception: a store with `write_mask`=0 issues no bus transaction and goes straight to DONE.
- **REQ**
  - Drive `bus_req`=1 with stable latched fields.
  - On `bus_gnt`, go to WAIT.
  - If `bus_gnt` and `bus_rvalid` arrive in the same cycle, handle the response now and go to DONE.
- **WAIT**
  - On `bus_rvalid`, go to DONE.
  - For a read, `load_data` ← `bus_rdata`. For a write, `load_data` is unchanged.
  - If `bus_err`=1 instead, `load_data` ← 0 and `mem_fault` pulses.
- **DONE**
  - Go to IDLE unconditionally.
  - The core advances at the end of this cycle, so the same request is never relaunched.
- **Stall**
  - `stall` = (IDLE & (`core_ld|core_st`)) | REQ | WAIT.
  - It is combinational in IDLE so the requesting instruction is held from its first cycle.
  - `stall`=0 in DONE.
- **Timeout**
  - The counter clears on entering REQ and increments in REQ and WAIT.
  - When it reaches `TIMEOUT_CYCLES`: `mem_fault` pulses, `load_data` ← 0 for reads, `bus_req` drops, and the FSM goes to DONE.
  - A late `bus_rvalid` arriving in IDLE or DONE is ignored.
- **Reset values:** state IDLE, `load_data`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `bus_wmask`=0, `mem_fault`=0, counter 0.

## Timing
- Minimum load, with `bus_gnt` in REQ and `bus_rvalid` the next cycle:
  - cycle 0: IDLE detect, `stall`=1.
  - cycle 1: REQ, `bus_req`=1.
  - cycle 2: WAIT, response arrives.
  - cycle 3: DONE, `stall`=0 and `load_data` valid.
- Same-cycle grant and response shortens this by one cycle.
- Bus fields are registered and stay constant from IDLE exit until DONE.
- `mem_fault` is asserted in the DONE cycle only.
- Reset mid-operation: in the cycle after reset is sampled, the FSM is in IDLE with `bus_req`=0. No fault pulse is generated.
- Back-to-back accesses:
  - DONE → IDLE → new request gives one idle cycle (`stall`=1 combinationally) between transactions.
  - `bus_req` is low for at least one cycle between transactions.

## Structure
- Shared header `data_bus_defs.vh`:
  - `` `DB_IDLE ``, `` `DB_REQ ``, `` `DB_WAIT ``, `` `DB_DONE `` as 2-bit state encodings.
  - Default timeout constant.
- Sub-module `bus_timeout_counter`:
  - 16-bit counter with `clear` and `enable` inputs.
  - `expired` output = (count == `TIMEOUT_CYCLES`).
  - Same synchronous active-high reset.
- The `data_bus_bridge` top module contains the FSM, latch registers and the `load_data` register.

## Test plan
- Load, address 0x0000_1004; `bus_gnt` in cycle 1; `bus_rvalid` with `bus_rdata`=0xDEAD_BEEF in cycle 2 → `stall` high cycles 0–2, low in cycle 3; `load_data`=0xDEAD_BEEF in cycle 3; `bus_wmask`=0.
- Store SB, `write_mask`=4'b0100, `write_data`=0x00AB_0000; `bus_gnt` delayed 4 cycles → `bus_req` held 5 cycles; `bus_we`=1 and `bus_wmask`=4'b0100 stable throughout; `load_data` unchanged.
- Load with `bus_rvalid`=1 and `bus_err`=1 → `mem_fault` one-cycle pulse in DONE; `load_data`=0.
- `TIMEOUT_CYCLES`=8, no `bus_gnt` → fault after 8 cycles in REQ; `bus_req` falls; a later stray `bus_rvalid` is ignored and state stays IDLE.
- `reset` asserted while in WAIT → next cycle IDLE, `bus_req`=0, `stall`=0 with no request, `mem_fault`=0.
- `core_ld`=`core_st`=1, mask 4'b1111 → a write transaction is issued; a store with mask 0 → DONE in cycle 1 with no `bus_req`.

Source files
------------

// File: rtl/data_bus_bridge_pkg.sv
// data_bus_bridge_pkg
//   Shared definitions for the load/store data bus bridge:
//   - db_state_t : FSM state encoding (IDLE, REQ, WAIT, DONE), 2 bits.
//   - DEFAULT_TIMEOUT_CYCLES : default REQ+WAIT cycle budget before a fault.
//   - in_bus_phase() : true while a bus transaction is outstanding.
package data_bus_bridge_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    DB_IDLE = 2'd0,
    DB_REQ  = 2'd1,
    DB_WAIT = 2'd2,
    DB_DONE = 2'd3
  } db_state_t;

  // REQ and WAIT are the states in which the bus owes us an answer; the
  // timeout counter runs only there.
  function automatic logic in_bus_phase(input db_state_t s);
    return (s == DB_REQ) || (s == DB_WAIT);
  endfunction

endpackage

// File: rtl/data_bus_bridge_timeout.sv
// bus_timeout_counter
//   16-bit cycle counter guarding one bus transaction.
//   Ports:
//     clk     in   clock, rising edge
//     reset   in   synchronous active-high reset (count -> 0)
//     clear   in   force count to 0 (priority over enable)
//     enable  in   increment count this cycle
//     expired out  count == TIMEOUT_CYCLES
module bus_timeout_counter
  import data_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] count;

  // Saturate rather than wrap so a stuck enable can never alias back to a
  // small value and hide an expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (enable && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/data_bus_bridge.sv
// data_bus_bridge
//   Runs one handshaked bus transaction per core load/store, stalling the
//   core until it completes, and returns the raw 32-bit load word.
//   Ports:
//     clk, reset                  clock / synchronous active-high reset
//     core_ld, core_st            access request from the current instruction
//     memory_addr, write_data,    word address, lane-positioned data and
//     write_mask                  byte enables from memory_controller
//     load_data                   registered load word
//     stall                       hold PC/pipeline while high
//     mem_fault                   one-cycle pulse (DONE) on bus error/timeout
//     bus_req, bus_we, bus_addr,  registered bus request fields, stable from
//     bus_wdata, bus_wmask        IDLE exit until DONE
//     bus_gnt, bus_rvalid,        bus grant and response channel
//     bus_rdata, bus_err
//     dbg_state                   current FSM state
//
//   Handshake: a request is accepted in the cycle where bus_req=1 and
//   bus_gnt=1; bus_req and all request fields stay constant until then.
//   A response is accepted in any REQ/WAIT cycle where bus_rvalid=1 after
//   (or together with) the grant; bus_rdata/bus_err are ignored otherwise.
//   There is no backpressure on the response channel.
//
//   Timeout: the counter is 0 in the first REQ cycle and counts every
//   REQ/WAIT cycle, so TIMEOUT_CYCLES full cycles are allowed; in the cycle
//   where it equals TIMEOUT_CYCLES the access is abandoned, and that takes
//   priority over a response arriving in the same cycle.
module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_ld,
  input  logic        core_st,
  input  logic [31:0] memory_addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        mem_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output db_state_t   dbg_state
);

  db_state_t state;
  db_state_t next_state;

  logic core_req;
  logic launch;
  logic resp_fire;
  logic timeout;
  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expired;

  assign core_req = core_ld | core_st;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the per-cycle events the datapath reacts to
  always_comb begin
    next_state = state;
    launch     = 1'b0;
    resp_fire  = 1'b0;
    timeout    = 1'b0;
    case (state)
      DB_IDLE: begin
        if (core_req) begin
          launch = 1'b1;
          // An all-zero store touches no byte, so no bus cycle is spent.
          if (core_st && (write_mask == 4'b0000)) begin
            next_state = DB_DONE;
          end else begin
            next_state = DB_REQ;
          end
        end
      end
      DB_REQ: begin
        if (cnt_expired) begin
          timeout    = 1'b1;
          next_state = DB_DONE;
        end else if (bus_gnt && bus_rvalid) begin
          resp_fire  = 1'b1;
          next_state = DB_DONE;
        end else if (bus_gnt) begin
          next_state = DB_WAIT;
        end
      end
      DB_WAIT: begin
        if (cnt_expired) begin
          timeout    = 1'b1;
          next_state = DB_DONE;
        end else if (bus_rvalid) begin
          resp_fire  = 1'b1;
          next_state = DB_DONE;
        end
      end
      DB_DONE: begin
        next_state = DB_IDLE;
      end
      default: begin
        next_state = DB_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    stall      = ((state == DB_IDLE) && core_req) || in_bus_phase(state);
    cnt_clear  = (state == DB_IDLE) && (next_state == DB_REQ);
    cnt_enable = in_bus_phase(state);
    dbg_state  = state;
  end

  // Request fields: captured once at IDLE exit, held until the next launch.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_wmask <= 4'd0;
    end else if (launch) begin
      bus_we    <= core_st;
      bus_addr  <= memory_addr;
      bus_wdata <= write_data;
      bus_wmask <= core_st ? write_mask : 4'd0;
    end
  end

  // bus_req is high exactly in REQ cycles, so it drops on grant or timeout
  // and is always low for DONE and the following IDLE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req   <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      bus_req   <= (next_state == DB_REQ);
      mem_fault <= timeout || (resp_fire && bus_err);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_data <= 32'd0;
    end else if (resp_fire) begin
      if (bus_err) begin
        load_data <= 32'd0;
      end else if (!bus_we) begin
        load_data <= bus_rdata;
      end
    end else if (timeout && !bus_we) begin
      load_data <= 32'd0;
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
module tb_data_bus_bridge;
  import data_bus_bridge_pkg::*;

  localparam int T = 8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        core_ld, core_st;
  logic [31:0] memory_addr, write_data;
  logic [3:0]  write_mask;
  logic [31:0] load_data;
  logic        stall, mem_fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;
  db_state_t   dbg_state;

  always #5 clk = ~clk;

  data_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .core_ld     (core_ld),
    .core_st     (core_st),
    .memory_addr (memory_addr),
    .write_data  (write_data),
    .write_mask  (write_mask),
    .load_data   (load_data),
    .stall       (stall),
    .mem_fault   (mem_fault),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wmask   (bus_wmask),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata),
    .bus_err     (bus_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];   // expected load word after each completed access
  logic [31:0] ld_model;   // architectural load_data the bridge should hold

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver + reference model ----------------
  // One access. The bus agent grants in the g-th REQ/WAIT cycle (0-based)
  // and responds in the same cycle (same=1) or r cycles after the grant
  // cycle. The model predicts the outcome from the timeout budget alone.
  task automatic run_txn(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask,
                         input int g, input bit same, input int r, input bit err,
                         input logic [31:0] rdata, input bit stray);
    bit   skip;
    bit   exp_fault;
    int   k_resp, k_end;
    logic [31:0] junk;

    skip = st && (mask == 4'b0000);
    k_resp = same ? g : g + 1 + r;
    if (skip) begin
      exp_fault = 1'b0;
      k_end = -1;
    end else if (k_resp < T) begin
      k_end = k_resp;
      exp_fault = err;
      if (err) ld_model = 32'd0;
      else if (!st) ld_model = rdata;
    end else begin
      k_end = T;
      exp_fault = 1'b1;
      if (!st) ld_model = 32'd0;
    end
    exp_q.push_back(ld_model);

    // IDLE detect cycle
    core_ld = ld; core_st = st; memory_addr = addr; write_data = wdata; write_mask = mask;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    @(negedge clk);
    check("idle_stall", 32'(stall), 32'd1);
    check("idle_state", 32'(dbg_state), 32'(DB_IDLE));
    next_cycle();

    // REQ / WAIT cycles
    for (int k = 0; k <= k_end; k++) begin
      junk = $urandom();
      bus_gnt    = (k == g);
      bus_rvalid = same ? (k == g) : (k == g + 1 + r);
      bus_rdata  = bus_rvalid ? rdata : junk;
      bus_err    = bus_rvalid & err;
      @(negedge clk);
      check("busy_stall", 32'(stall), 32'd1);
      check("bus_req", 32'(bus_req), 32'(k <= g));
      check("bus_state", 32'(dbg_state), 32'((k <= g) ? DB_REQ : DB_WAIT));
      check("bus_we", 32'(bus_we), 32'(st));
      check("bus_addr", bus_addr, addr);
      check("bus_wdata", bus_wdata, wdata);
      check("bus_wmask", 32'(bus_wmask), 32'(st ? mask : 4'd0));
      check("busy_fault", 32'(mem_fault), 32'd0);
      next_cycle();
    end

    // DONE cycle: core still presents the instruction
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    @(negedge clk);
    check("done_state", 32'(dbg_state), 32'(DB_DONE));
    check("done_stall", 32'(stall), 32'd0);
    check("done_fault", 32'(mem_fault), 32'(exp_fault));
    check("done_req", 32'(bus_req), 32'd0);
    check("load_data", load_data, exp_q.pop_front());
    next_cycle();

    // Following IDLE cycle, optionally with a stray response
    core_ld = 1'b0; core_st = 1'b0;
    if (stray) begin
      bus_rvalid = 1'b1; bus_rdata = $urandom(); bus_err = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("post_state", 32'(dbg_state), 32'(DB_IDLE));
    check("post_stall", 32'(stall), 32'd0);
    check("post_fault", 32'(mem_fault), 32'd0);
    check("post_req", 32'(bus_req), 32'd0);
    check("post_load", load_data, ld_model);
    next_cycle();
    bus_rvalid = 1'b0; bus_err = 1'b0;
    next_cycle();
    check("stray_ignored", load_data, ld_model);
  endtask

  // Reset while waiting for a read response.
  task automatic reset_in_wait();
    core_ld = 1'b1; core_st = 1'b0; memory_addr = 32'h0000_2000; write_mask = 4'hF;
    next_cycle();                 // IDLE -> REQ
    bus_gnt = 1'b1;
    next_cycle();                 // REQ -> WAIT
    bus_gnt = 1'b0;
    @(negedge clk);
    check("rst_pre_state", 32'(dbg_state), 32'(DB_WAIT));
    next_cycle();
    reset = 1'b1; core_ld = 1'b0;
    next_cycle();
    reset = 1'b0;
    ld_model = 32'd0;
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(DB_IDLE));
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fault", 32'(mem_fault), 32'd0);
    check("rst_load", load_data, ld_model);
    next_cycle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    core_ld = 1'b0; core_st = 1'b0;
    memory_addr = 32'd0; write_data = 32'd0; write_mask = 4'd0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0; bus_err = 1'b0;
    ld_model = 32'd0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset_state", 32'(dbg_state), 32'(DB_IDLE));
    check("reset_load", load_data, 32'd0);
    check("reset_req", 32'(bus_req), 32'd0);
    check("reset_we", 32'(bus_we), 32'd0);
    check("reset_addr", bus_addr, 32'd0);
    check("reset_wdata", bus_wdata, 32'd0);
    check("reset_wmask", 32'(bus_wmask), 32'd0);
    check("reset_fault", 32'(mem_fault), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Directed cases
    run_txn(1, 0, 32'h0000_1004, 32'h1111_2222, 4'hF, 0, 0, 0, 0, 32'hDEAD_BEEF, 0);
    run_txn(0, 1, 32'h0000_2008, 32'h00AB_0000, 4'b0100, 4, 0, 1, 0, 32'h5555_AAAA, 0);
    run_txn(1, 0, 32'h0000_3000, 32'h0, 4'hF, 0, 1, 0, 0, 32'h0BAD_F00D, 0);
    run_txn(1, 0, 32'h0000_300C, 32'h0, 4'hF, 1, 0, 0, 1, 32'hCAFE_CAFE, 0);
    run_txn(1, 0, 32'h0000_1234 & 32'hFFFF_FFFC, 32'h0, 4'hF, 20, 0, 0, 0, 32'h7777_7777, 1);
    run_txn(1, 1, 32'h0000_4000, 32'hA5A5_5A5A, 4'b1111, 2, 0, 2, 0, 32'h0, 0);
    run_txn(0, 1, 32'h0000_4004, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, 0, 32'h0, 0);
    run_txn(1, 0, 32'h0000_5000, 32'h0, 4'hF, 2, 0, 5, 0, 32'h1357_9BDF, 0);
    run_txn(0, 1, 32'h0000_5004, 32'h0102_0304, 4'b0011, 7, 1, 0, 0, 32'h0, 0);

    reset_in_wait();

    // Randomized accesses
    for (int i = 0; i < 150; i++) begin
      logic        ld, st;
      logic [31:0] a;
      ld = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      if (!ld && !st) ld = 1'b1;
      a = $urandom() & 32'hFFFF_FFFC;
      run_txn(ld, st, a, $urandom(), 4'($urandom_range(0, 15)),
              $urandom_range(0, 10), 1'($urandom_range(0, 1)), $urandom_range(0, 6),
              ($urandom_range(0, 3) == 0), $urandom(), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
